// File: rtl/bldc_commutator_pkg.sv
// Shared types, sector arithmetic, hall decode and the six-step commutation table
// used by the BLDC commutation engine.
package bldc_commutator_pkg;

   typedef logic [2:0] sector_t;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DEAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_BRAKE = 2'd3
   } comm_state_e;

   typedef struct packed {
      logic    valid;
      sector_t sec;
   } hall_dec_t;

   typedef struct packed {
      logic [2:0] h;
      logic [2:0] l;
   } gates_t;

   localparam sector_t SECTOR_LAST = 3'd5;

   function automatic sector_t sector_next(input sector_t s);
      return (s >= SECTOR_LAST) ? 3'd0 : s + 3'd1;
   endfunction

   function automatic sector_t sector_prev(input sector_t s);
      return (s == 3'd0) ? SECTOR_LAST : s - 3'd1;
   endfunction

   // Hall code {h3,h2,h1}; 000 and 111 are never produced by a healthy sensor set.
   function automatic hall_dec_t hall_decode(input logic [2:0] code);
      hall_dec_t d;
      d.valid = 1'b1;
      d.sec   = 3'd0;
      case (code)
         3'b101:  d.sec = 3'd0;
         3'b001:  d.sec = 3'd1;
         3'b011:  d.sec = 3'd2;
         3'b010:  d.sec = 3'd3;
         3'b110:  d.sec = 3'd4;
         3'b100:  d.sec = 3'd5;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

   // Bit order {C,B,A}; reverse rotation uses the pattern three sectors ahead.
   function automatic gates_t comm_table(input sector_t s, input logic dir);
      sector_t idx;
      gates_t  g;
      idx = dir ? s : ((s >= 3'd3) ? s - 3'd3 : s + 3'd3);
      case (idx)
         3'd0:    g = '{h: 3'b100, l: 3'b010};
         3'd1:    g = '{h: 3'b001, l: 3'b010};
         3'd2:    g = '{h: 3'b001, l: 3'b100};
         3'd3:    g = '{h: 3'b010, l: 3'b100};
         3'd4:    g = '{h: 3'b010, l: 3'b001};
         3'd5:    g = '{h: 3'b100, l: 3'b001};
         default: g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// Control/status bundle between the motor controller and the commutation engine.
interface bldc_commutator_if #(
   parameter int unsigned PERIOD_W = 24
);
   logic [2:0]          hall;
   logic                enable;
   logic                dir;
   logic                brake;
   logic                pwm;
   logic                fault_n;
   logic                clear_fault;
   logic [2:0]          INH;
   logic [2:0]          INL;
   logic [2:0]          sector;
   logic                fault;
   logic                stalled;
   logic [PERIOD_W-1:0] period;
   logic [31:0]         step_count;

   modport master (
      output hall, enable, dir, brake, pwm, fault_n, clear_fault,
      input  INH, INL, sector, fault, stalled, period, step_count
   );

   modport slave (
      input  hall, enable, dir, brake, pwm, fault_n, clear_fault,
      output INH, INL, sector, fault, stalled, period, step_count
   );
endinterface

// File: rtl/bldc_commutator_hall_filter.sv
// Two-flop synchroniser plus debounce for the 3-bit hall bus; pulses upd when a
// new code has been seen FILTER consecutive times.
module bldc_commutator_hall_filter #(
   parameter int unsigned FILTER = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [2:0] pin,
   output logic [2:0] filt,
   output logic       valid,
   output logic       upd
);
   localparam int unsigned CW = $clog2(FILTER + 1);

   logic [2:0]    s1_q, s2_q;
   logic          v1_q, v2_q;
   logic [2:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    filt_q, filt_d;
   logic          valid_q, valid_d;
   logic          upd_q, upd_d;

   // v1/v2 keep the debouncer from counting the reset contents of the synchroniser.
   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      filt_d  = filt_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      if (v2_q) begin
         if ((s2_q != cand_q) || (cnt_q == '0)) begin
            cand_d = s2_q;
            cnt_d  = CW'(1);
         end else if (cnt_q != CW'(FILTER)) begin
            cnt_d = cnt_q + CW'(1);
         end
         if ((cnt_d == CW'(FILTER)) && ((cand_d != filt_q) || !valid_q)) begin
            filt_d  = cand_d;
            valid_d = 1'b1;
            upd_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         cand_q  <= '0;
         cnt_q   <= '0;
         filt_q  <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         s1_q    <= pin;
         s2_q    <= s1_q;
         v1_q    <= 1'b1;
         v2_q    <= v1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
      end
   end

   assign filt  = filt_q;
   assign valid = valid_q;
   assign upd   = upd_q;
endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation engine: hall decode and step tracking, period/stall
// reporting, fault latch, and the OFF/DEAD/DRIVE/BRAKE gate sequencer.
module bldc_commutator
   import bldc_commutator_pkg::*;
#(
   parameter int unsigned DEADTIME_CYCLES = 1024,
   parameter int unsigned HALL_FILTER     = 4,
   parameter int unsigned STALL_CYCLES    = 16_000_000,
   parameter int unsigned PERIOD_W        = 24
) (
   input logic              CLK,
   input logic              reset,
   bldc_commutator_if.slave bus
);
   localparam int unsigned DW = $clog2(DEADTIME_CYCLES + 1);

   logic [2:0]          filt;
   logic                filt_valid, filt_upd;
   hall_dec_t           dec;
   logic                hall_valid, hall_err, sec_chg, fault_clr, evt;
   logic                have_q, have_d;
   sector_t             sector_q, sector_d;
   logic [31:0]         step_q, step_d;
   logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
   logic                stalled_q, stalled_d;
   logic                fault_n_s1_q, fault_n_s2_q;
   logic                fault_q, fault_d;
   logic                dir_q, brake_q;
   comm_state_e         state_q, state_d;
   logic [DW-1:0]       dead_q, dead_d;
   logic [2:0]          gh_q, gh_d, gl_q, gl_d;
   gates_t              drive_pat;

   bldc_commutator_hall_filter #(.FILTER(HALL_FILTER)) u_hall_filter (
      .CLK   (CLK),
      .reset (reset),
      .pin   (bus.hall),
      .filt  (filt),
      .valid (filt_valid),
      .upd   (filt_upd)
   );

   always_comb begin
      dec        = hall_decode(filt);
      hall_valid = filt_valid & dec.valid;
      fault_clr  = bus.clear_fault & fault_n_s2_q & hall_valid;
      sector_d   = sector_q;
      step_d     = step_q;
      have_d     = have_q;
      hall_err   = 1'b0;
      sec_chg    = 1'b0;
      if (filt_upd) begin
         if (!dec.valid) begin
            hall_err = 1'b1;
         end else if (!have_q) begin
            sector_d = dec.sec;
            have_d   = 1'b1;
         end else if (dec.sec == sector_next(sector_q)) begin
            sector_d = dec.sec;
            step_d   = step_q + 32'd1;
            sec_chg  = 1'b1;
         end else if (dec.sec == sector_prev(sector_q)) begin
            sector_d = dec.sec;
            step_d   = step_q - 32'd1;
            sec_chg  = 1'b1;
         end else if (dec.sec != sector_q) begin
            hall_err = 1'b1;
         end
      end else if (fault_q && fault_clr) begin
         // The held sector may lag the rotor after a jump; realign without counting a step.
         sector_d = dec.sec;
         have_d   = 1'b1;
      end

      fault_d = fault_q;
      if (!fault_n_s2_q || hall_err) begin
         fault_d = 1'b1;
      end else if (fault_clr) begin
         fault_d = 1'b0;
      end

      pcnt_d    = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);
      period_d  = period_q;
      stalled_d = stalled_q;
      if (sec_chg) begin
         period_d  = pcnt_d;
         pcnt_d    = '0;
         stalled_d = 1'b0;
      end else if (32'(pcnt_q) >= STALL_CYCLES - 1) begin
         stalled_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      evt     = sec_chg | (bus.dir != dir_q) | (bus.brake != brake_q);
      if (!bus.enable || fault_d) begin
         state_d = ST_OFF;
         dead_d  = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (hall_valid) begin
                  state_d = ST_DEAD;
                  dead_d  = '0;
               end
            end
            ST_DEAD: begin
               if (evt) begin
                  dead_d = '0;
               end else if (dead_q == DW'(DEADTIME_CYCLES - 1)) begin
                  state_d = bus.brake ? ST_BRAKE : ST_DRIVE;
                  dead_d  = '0;
               end else begin
                  dead_d = dead_q + DW'(1);
               end
            end
            ST_DRIVE: begin
               if (sec_chg || (bus.dir != dir_q) || bus.brake) begin
                  state_d = ST_DEAD;
                  dead_d  = '0;
               end
            end
            ST_BRAKE: begin
               if (!bus.brake) begin
                  state_d = ST_DEAD;
                  dead_d  = '0;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // Gates follow the next state so every pattern change is preceded by an all-off edge.
   always_comb begin
      gh_d      = '0;
      gl_d      = '0;
      drive_pat = comm_table(sector_d, bus.dir);
      case (state_d)
         ST_DRIVE: begin
            gh_d = drive_pat.h;
            gl_d = drive_pat.l;
         end
         ST_BRAKE: gl_d = '1;
         default:  ;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         dead_q  <= '0;
         gh_q    <= '0;
         gl_q    <= '0;
      end else begin
         state_q <= state_d;
         dead_q  <= dead_d;
         gh_q    <= gh_d;
         gl_q    <= gl_d;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         have_q       <= 1'b0;
         sector_q     <= '0;
         step_q       <= '0;
         pcnt_q       <= '0;
         period_q     <= '1;
         stalled_q    <= 1'b0;
         fault_n_s1_q <= 1'b1;
         fault_n_s2_q <= 1'b1;
         fault_q      <= 1'b0;
         dir_q        <= 1'b0;
         brake_q      <= 1'b0;
      end else begin
         have_q       <= have_d;
         sector_q     <= sector_d;
         step_q       <= step_d;
         pcnt_q       <= pcnt_d;
         period_q     <= period_d;
         stalled_q    <= stalled_d;
         fault_n_s1_q <= bus.fault_n;
         fault_n_s2_q <= fault_n_s1_q;
         fault_q      <= fault_d;
         dir_q        <= bus.dir;
         brake_q      <= bus.brake;
      end
   end

   assign bus.INH        = gh_q & {3{bus.pwm}};
   assign bus.INL        = gl_q;
   assign bus.sector     = sector_q;
   assign bus.fault      = fault_q;
   assign bus.stalled    = stalled_q;
   assign bus.period     = period_q;
   assign bus.step_count = step_q;
endmodule
